instruction_fetch: RTL and testbench

Instruction fetch/sequencer stage directly upstream of the control unit.
- Owns the program counter (PC).
- Fetches 8-bit opcodes from program memory over a req/ack handshake.
- Holds each opcode in an instruction register (IR) and drives the control unit's 8-bit `inst` input.
- Advances, jumps or halts when the control unit signals that the current instruction has finished executing.

---
 rtl/instruction_fetch.sv | 83 ++++++++
 tb/tb_instruction_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch/sequencer: owns the PC, fetches 8-bit opcodes over req/ack,
// holds them in the IR for the control unit and advances, jumps or halts on instDone.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memReq,
   input  logic                  memAck,
   input  logic [7:0]            memData,
   output logic [7:0]            inst,
   output logic                  instValid,
   input  logic                  instDone,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jumpAddr,
   input  logic                  halt,
   output logic [ADDR_WIDTH-1:0] pc
);

   typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [7:0]            r_ir;
   logic                  r_memReq;
   logic                  r_instValid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= 8'h00;
         r_memReq    <= 1'b0;
         r_instValid <= 1'b0;
      end else begin
         case (r_state)
            // An ack is taken even before memReq rises, so a late ack that
            // straddles a reset is accepted as the RESET_PC fetch.
            FETCH: begin
               if (memAck) begin
                  r_ir        <= memData;
                  r_instValid <= 1'b1;
                  r_memReq    <= 1'b0;
                  r_state     <= EXEC;
               end else begin
                  r_memReq    <= 1'b1;
               end
            end
            EXEC: begin
               if (instDone) begin
                  r_pc        <= jump ? jumpAddr : r_pc + ADDR_WIDTH'(1);
                  r_instValid <= 1'b0;
                  if (halt) begin
                     r_state  <= HALTED;
                     r_memReq <= 1'b0;
                  end else begin
                     r_state  <= FETCH;
                     r_memReq <= 1'b1;
                  end
               end
            end
            HALTED: begin
               r_memReq    <= 1'b0;
               r_instValid <= 1'b0;
            end
            default: begin
               r_state     <= FETCH;
               r_memReq    <= 1'b0;
               r_instValid <= 1'b0;
            end
         endcase
      end
   end

   assign memAddr   = r_pc;
   assign pc        = r_pc;
   assign memReq    = r_memReq;
   assign instValid = r_instValid;
   assign inst      = r_instValid ? r_ir : 8'h00;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fetched opcodes go into a scoreboard
// queue and are popped when the DUT presents them on inst.
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       rst, memReq, memAck, instValid, instDone, jump, halt;
   logic [7:0] memAddr, memData, inst, jumpAddr, pc;

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] sb_q[$];

   instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .memAddr(memAddr), .memReq(memReq), .memAck(memAck),
      .memData(memData), .inst(inst), .instValid(instValid), .instDone(instDone),
      .jump(jump), .jumpAddr(jumpAddr), .halt(halt), .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare inst against the oldest scoreboard entry.
   task automatic chk_inst(input string tag);
      logic [7:0] e;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL %s observed=%0h expected=scoreboard entry (queue empty)", tag, inst);
      end else begin
         e = sb_q.pop_front();
         chk(tag, {24'h0, inst}, {24'h0, e});
      end
   endtask

   // Ack the pending request with d; expects to land in EXEC.
   task automatic fetch(input logic [7:0] d, input logic [7:0] exp_pc, input string tag);
      chk({tag, "_req"}, {31'h0, memReq}, 32'h1);
      chk({tag, "_addr"}, {24'h0, memAddr}, {24'h0, exp_pc});
      memAck = 1'b1; memData = d; sb_q.push_back(d);
      step();
      memAck = 1'b0; memData = 8'h00;
      chk({tag, "_valid"}, {31'h0, instValid}, 32'h1);
      chk({tag, "_reqlo"}, {31'h0, memReq}, 32'h0);
      chk_inst({tag, "_inst"});
   endtask

   // Complete the current instruction; expects FETCH (or HALTED) afterwards.
   task automatic done(input logic j, input logic [7:0] ja, input logic h,
                       input logic [7:0] exp_pc, input string tag);
      instDone = 1'b1; jump = j; jumpAddr = ja; halt = h;
      step();
      instDone = 1'b0; jump = 1'b0; jumpAddr = 8'h00; halt = 1'b0;
      chk({tag, "_pc"}, {24'h0, pc}, {24'h0, exp_pc});
      chk({tag, "_valid"}, {31'h0, instValid}, 32'h0);
      chk({tag, "_inst"}, {24'h0, inst}, 32'h0);
      chk({tag, "_req"}, {31'h0, memReq}, {31'h0, ~h});
   endtask

   initial begin
      rst = 1'b1; memAck = 1'b1; memData = 8'hFF;
      instDone = 1'b0; jump = 1'b0; jumpAddr = 8'h00; halt = 1'b0;

      // Reset held with a live ack on the bus
      step(); step();
      chk("rst_req", {31'h0, memReq}, 32'h0);
      chk("rst_valid", {31'h0, instValid}, 32'h0);
      chk("rst_inst", {24'h0, inst}, 32'h0);
      chk("rst_pc", {24'h0, pc}, 32'h0);

      rst = 1'b0; memAck = 1'b0; memData = 8'h00;
      step();
      chk("first_req", {31'h0, memReq}, 32'h1);

      // Back-to-back instructions
      fetch(8'h11, 8'h00, "f11");
      done(1'b0, 8'h00, 1'b0, 8'h01, "d11");
      fetch(8'h22, 8'h01, "f22");
      done(1'b0, 8'h00, 1'b0, 8'h02, "d22");

      // Slow memory: request held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk("wait_req", {31'h0, memReq}, 32'h1);
         chk("wait_addr", {24'h0, memAddr}, 32'h02);
         chk("wait_valid", {31'h0, instValid}, 32'h0);
         chk("wait_inst", {24'h0, inst}, 32'h0);
      end
      fetch(8'h33, 8'h02, "f33");
      done(1'b0, 8'h00, 1'b0, 8'h03, "d33");

      // Jump, then PC wrap from FF
      fetch(8'h44, 8'h03, "f44");
      done(1'b1, 8'h40, 1'b0, 8'h40, "jmp40");
      chk("jmp_addr", {24'h0, memAddr}, 32'h40);
      fetch(8'h45, 8'h40, "f45");
      // jump/halt without instDone are ignored
      jump = 1'b1; jumpAddr = 8'h99; halt = 1'b1;
      step();
      jump = 1'b0; jumpAddr = 8'h00; halt = 1'b0;
      chk("nodone_pc", {24'h0, pc}, 32'h40);
      chk("nodone_valid", {31'h0, instValid}, 32'h1);
      done(1'b1, 8'hFF, 1'b0, 8'hFF, "jmpFF");
      fetch(8'h46, 8'hFF, "f46");
      done(1'b0, 8'h00, 1'b0, 8'h00, "wrap");

      // Ack during EXEC must not overwrite the IR
      fetch(8'h55, 8'h00, "f55");
      memAck = 1'b1; memData = 8'hAA;
      step();
      memAck = 1'b0; memData = 8'h00;
      chk("exec_ack_inst", {24'h0, inst}, 32'h55);
      chk("exec_ack_valid", {31'h0, instValid}, 32'h1);
      done(1'b0, 8'h00, 1'b0, 8'h01, "d55");

      // Jump + halt together
      fetch(8'h66, 8'h01, "f66");
      done(1'b1, 8'h10, 1'b1, 8'h10, "halt");
      for (int i = 0; i < 3; i++) begin
         memAck = 1'b1; memData = 8'h77; instDone = 1'b1; jump = i[0]; jumpAddr = 8'h20;
         step();
         chk("hlt_pc", {24'h0, pc}, 32'h10);
         chk("hlt_req", {31'h0, memReq}, 32'h0);
         chk("hlt_inst", {24'h0, inst}, 32'h0);
      end
      memAck = 1'b0; memData = 8'h00; instDone = 1'b0; jump = 1'b0; jumpAddr = 8'h00;

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("hrst_pc", {24'h0, pc}, 32'h0);
      step();
      chk("hrst_req", {31'h0, memReq}, 32'h1);

      // Reset while a request is outstanding
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rreq_req", {31'h0, memReq}, 32'h0);
      step();
      fetch(8'h88, 8'h00, "f88");

      // Reset while executing
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rexe_valid", {31'h0, instValid}, 32'h0);
      chk("rexe_inst", {24'h0, inst}, 32'h0);
      chk("rexe_pc", {24'h0, pc}, 32'h0);

      // Late ack right after reset, before memReq rises, is accepted
      memAck = 1'b1; memData = 8'h99; sb_q.push_back(8'h99);
      step();
      memAck = 1'b0; memData = 8'h00;
      chk("late_valid", {31'h0, instValid}, 32'h1);
      chk_inst("late_inst");
      chk("late_sb_empty", sb_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
